// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file writes, drains them in order one per
// cycle, and offers a combinational forwarding lookup over pending entries.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4:0]             in_addr,
   input  logic [31:0]            in_data,
   input  logic                   drain_en,
   output logic [4:0]             A3,
   output logic [31:0]            WD3,
   output logic                   WE,
   input  logic [4:0]             q_addr,
   output logic                   q_hit,
   output logic [31:0]            q_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [4:0]       addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] idx;
   logic             push;
   logic             pop;

   // Handshake: a request transfers at a rising edge where in_valid && in_ready;
   // in_ready never depends on in_valid. Address-0 requests transfer but are dropped.
   assign in_ready = rst_n && (count < CNT_W'(DEPTH));
   assign push     = in_valid && in_ready && (in_addr != 5'd0);
   assign WE       = rst_n && drain_en && (count != '0);
   assign pop      = WE;
   assign A3       = addr_mem[head];
   assign WD3      = data_mem[head];

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail] <= in_addr;
         data_mem[tail] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Walk oldest to newest so the last match (closest to tail) wins; the head
   // entry being popped this cycle is still counted as pending.
   always_comb begin
      q_hit  = 1'b0;
      q_data = '0;
      idx    = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (rst_n && (q_addr != 5'd0) && (CNT_W'(i) < count) &&
             (addr_mem[idx] == q_addr)) begin
            q_hit  = 1'b1;
            q_data = data_mem[idx];
         end
      end
   end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of pending write entries; legal values are powers of two from 2 to 16.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a write request is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the queue accepts a request this cycle.
REQ-006 The block SHALL have port in_addr, input, 5 bits: destination register of the request.
REQ-007 The block SHALL have port in_data, input, 32 bits: data of the request.
REQ-008 The block SHALL have port drain_en, input, 1 bit: permits issuing writes to the register file.
REQ-009 The block SHALL have port A3, output, 5 bits: register-file write address.
REQ-010 The block SHALL have port WD3, output, 32 bits: register-file write data.
REQ-011 The block SHALL have port WE, output, 1 bit: register-file write enable.
REQ-012 The block SHALL have port q_addr, input, 5 bits: forwarding lookup address.
REQ-013 The block SHALL have port q_hit, output, 1 bit: a pending entry matches q_addr.
REQ-014 The block SHALL have port q_data, output, 32 bits: data of the newest matching pending entry.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of pending entries.

Function
REQ-016 The block SHALL be a circular FIFO of DEPTH entries {addr[4:0], data[31:0]} with head and tail pointers wrapping modulo DEPTH.
REQ-017 The block SHALL drive in_ready = rst_n && (count < DEPTH); a request is accepted when in_valid && in_ready at a rising edge.
REQ-018 The block SHALL accept in_addr = 0 requests but SHALL NOT store them: count is unchanged and the register file is never written at address 0.
REQ-019 The block SHALL drive WE = rst_n && drain_en && (count != 0), combinationally, with A3/WD3 equal to the head entry.
REQ-020 The block SHALL pop the head entry at every rising edge where WE = 1; exactly one register-file write per cycle.
REQ-021 When WE = 0, A3 and WD3 SHALL hold the head entry value; their values are don't-care for the register file.
REQ-022 On a cycle with both an accepted, stored push and a pop, count SHALL be unchanged, and both pointers SHALL advance.
REQ-023 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; there is no full-queue pass-through.
REQ-024 A request accepted at edge N SHALL appear on A3/WD3 with WE = 1 no earlier than the cycle after edge N; an empty queue has no combinational bypass.
REQ-025 Write order SHALL match acceptance order, including repeated writes to the same address.
REQ-026 q_hit SHALL be 1 iff any pending entry has addr == q_addr and q_addr != 0; the lookup is combinational.
REQ-027 q_data SHALL be the newest (closest to tail) matching entry; when q_hit = 0, q_data SHALL be 0.
REQ-028 The entry being popped in the current cycle SHALL still count as pending for q_hit/q_data.

Reset
REQ-029 With rst_n = 0 at a rising edge, head, tail and count SHALL become 0; entry contents need not be cleared.
REQ-030 While rst_n = 0, in_ready, WE and q_hit SHALL be 0, and q_data SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending entries; no write from them may occur after the reset edge.

Verification
REQ-032 Directed test: after reset, push (5, 0xAAAA0001), (6, 0xBBBB0002), then (5, 0xCCCC0003) with drain_en = 0 -> count = 3; q_addr = 5 gives q_hit = 1 and q_data = 0xCCCC0003; raising drain_en gives writes 5/0xAAAA0001, 6/0xBBBB0002, 5/0xCCCC0003 on consecutive cycles, then WE = 0.
REQ-033 Directed test: push (0, 0xDEADBEEF) -> in_ready = 1 during the push, count stays 0, WE never asserts, and q_addr = 0 gives q_hit = 0.
REQ-034 Directed test: with DEPTH = 4 and drain_en = 0, push 4 entries -> in_ready = 0 and a fifth push is not accepted; then, with drain_en = 1 and in_valid held, one pop per cycle reopens in_ready the next cycle, and all entries drain in order across pointer wrap.
REQ-035 Directed test: with drain_en = 1, hold a continuous push every cycle to addresses 1..8 -> count stays at 1, writes occur one cycle after each acceptance, and no entry is lost or duplicated.
REQ-036 Directed test: with 3 entries pending, pull rst_n low for one edge -> count = 0, WE = 0 and q_hit = 0 immediately after; no stale write occurs once rst_n returns high.
